// File: rtl/frog_draw_pkg.sv
// Shared constants for the frame draw engine: FSM state encoding and ROM screen indices.
package frog_draw_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    localparam int SCR_START     = 0;
    localparam int SCR_GAME_OVER = 1;
    localparam int SCR_SUCCESS   = 2;
    localparam int SCR_GAME_BG   = 3;

endpackage

// File: rtl/draw_delay_line.sv
// DEPTH-stage {valid,data} shift register that keeps pixel coordinates aligned with ROM data.
// Data only moves with a valid entry, so the output coordinates hold their last value between plots.
module draw_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          pending_o
);

    logic [DEPTH-1:0] vld_w;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic          v_in;
            logic [DW-1:0] d_in;
            logic          v_q;
            logic [DW-1:0] d_q;

            if (gi == 0) begin : g_head
                assign v_in = valid_i;
                assign d_in = data_i;
            end else begin : g_tail
                assign v_in = g_stage[gi-1].v_q;
                assign d_in = g_stage[gi-1].d_q;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                end else begin
                    v_q <= v_in & ~flush_i;
                    if (v_in) begin
                        d_q <= d_in;
                    end
                end
            end

            assign vld_w[gi] = v_q;
        end

        // The last stage drains on its own; only earlier stages hold work still to come.
        if (DEPTH > 1) begin : g_pend
            assign pending_o = |vld_w[DEPTH-2:0];
        end else begin : g_nopend
            assign pending_o = 1'b0;
        end
    endgenerate

    assign valid_o = vld_w[DEPTH-1];
    assign data_o  = g_stage[DEPTH-1].d_q;

endmodule

// File: rtl/frame_draw_sequencer.sv
// Full-frame draw engine: walks every pixel of the selected screen, issues linear ROM
// addresses and plots coordinates realigned with the ROM read latency.
module frame_draw_sequencer
    import frog_draw_pkg::*;
#(
    parameter int  SCREEN_W    = 160,
    parameter int  SCREEN_H    = 120,
    parameter int  X_W         = 8,
    parameter int  Y_W         = 7,
    parameter int  NUM_SCREENS = 4,
    parameter int  SEL_W       = 2,
    parameter int  ROM_LAT     = 1,
    localparam int ADDR_W      = $clog2(SCREEN_W*SCREEN_H)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              go_i,
    input  logic [SEL_W-1:0]  screen_id_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [SEL_W-1:0]  rom_sel_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic              plot_o
);

    localparam logic [SEL_W:0]  NUM_SCR = (SEL_W+1)'(NUM_SCREENS);
    localparam logic [X_W-1:0]  X_LAST  = X_W'(SCREEN_W-1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(SCREEN_H-1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               err_q, err_d;

    logic               issue;
    logic               flush;
    logic               id_ok;
    logic               pending;
    logic [X_W+Y_W-1:0] dl_data;

    assign id_ok = {1'b0, screen_id_i} < NUM_SCR;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        issue   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Abort alongside go cancels the request outright.
                if (go_i && !abort_i) begin
                    if (id_ok) begin
                        sel_d   = screen_id_i;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                        state_d = ST_FETCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    issue = 1'b1;
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        state_d = ST_DRAIN;
                    end else if (x_q == X_LAST) begin
                        x_d    = '0;
                        y_d    = y_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end else begin
                        x_d    = x_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = ST_DONE;
                end else if (!pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            sel_q   <= SEL_W'(SCR_START);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    draw_delay_line #(
        .DEPTH (ROM_LAT),
        .DW    (X_W + Y_W)
    ) u_delay (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush),
        .valid_i   (issue),
        .data_i    ({x_q, y_q}),
        .valid_o   (plot_o),
        .data_o    (dl_data),
        .pending_o (pending)
    );

    assign x_o        = dl_data[X_W+Y_W-1:Y_W];
    assign y_o        = dl_data[Y_W-1:0];
    assign busy_o     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = err_q;
    assign rom_sel_o  = sel_q;
    assign rom_addr_o = addr_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Randomised bench for frame_draw_sequencer; expectations come from a cycle-indexed model of a draw.
module tb_frame_draw_sequencer;

    localparam int SCREEN_W    = 4;
    localparam int SCREEN_H    = 3;
    localparam int X_W         = 2;
    localparam int Y_W         = 2;
    localparam int SEL_W       = 3;
    localparam int NUM_SCREENS = 4;
    localparam int ROM_LAT     = 2;
    localparam int N_PIX       = SCREEN_W * SCREEN_H;
    localparam int ADDR_W      = $clog2(N_PIX);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              go_i = 1'b0;
    logic [SEL_W-1:0]  screen_id_i = '0;
    logic              abort_i = 1'b0;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [SEL_W-1:0]  rom_sel_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [X_W-1:0]    x_o;
    logic [Y_W-1:0]    y_o;
    logic              plot_o;

    int n_cmp = 0;
    int n_err = 0;
    int sel_exp = 0;

    frame_draw_sequencer #(
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .NUM_SCREENS (NUM_SCREENS),
        .SEL_W       (SEL_W),
        .ROM_LAT     (ROM_LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .go_i        (go_i),
        .screen_id_i (screen_id_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rom_sel_o   (rom_sel_o),
        .rom_addr_o  (rom_addr_o),
        .x_o         (x_o),
        .y_o         (y_o),
        .plot_o      (plot_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".busy"}, 32'(busy_o), 0);
        check_val({tag, ".done"}, 32'(done_o), 0);
        check_val({tag, ".err"}, 32'(err_o), 0);
        check_val({tag, ".plot"}, 32'(plot_o), 0);
        check_val({tag, ".sel"}, 32'(rom_sel_o), 0);
        check_val({tag, ".addr"}, 32'(rom_addr_o), 0);
        check_val({tag, ".x"}, 32'(x_o), 0);
        check_val({tag, ".y"}, 32'(y_o), 0);
    endtask

    // Cycle c is the c-th cycle after the edge that samples go. abort_at is the cycle
    // during which abort is held (0 = none); rst_at drops reset inside cycle c.
    task automatic run_draw(input int id, input int abort_at, input int extra_go_at,
                            input bit go_in_done, input int rst_at);
        int  done_c;
        int  plots;
        int  px;
        bit  ok;
        bit  e_plot;
        ok = (id < NUM_SCREENS);
        if (!ok)
            done_c = 1;
        else if (abort_at > 0 && abort_at <= N_PIX + ROM_LAT)
            done_c = abort_at + 1;
        else
            done_c = N_PIX + ROM_LAT + 1;
        plots = 0;
        go_i        = 1'b1;
        abort_i     = 1'b0;
        screen_id_i = SEL_W'(id);
        @(posedge clk_i);
        if (ok) sel_exp = id;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk_i);
            e_plot = ok && c >= 1 + ROM_LAT && c <= N_PIX + ROM_LAT &&
                     (abort_at == 0 || c <= abort_at);
            check_val("busy", 32'(busy_o), 32'(ok && c < done_c));
            check_val("done", 32'(done_o), 32'(c == done_c));
            check_val("err", 32'(err_o), 32'(!ok && c == done_c));
            check_val("plot", 32'(plot_o), 32'(e_plot));
            check_val("rom_sel", 32'(rom_sel_o), sel_exp);
            if (e_plot) begin
                px = c - 1 - ROM_LAT;
                plots++;
                check_val("x", 32'(x_o), px % SCREEN_W);
                check_val("y", 32'(y_o), px / SCREEN_W);
            end
            if (ok && c <= N_PIX && (abort_at == 0 || c <= abort_at))
                check_val("rom_addr", 32'(rom_addr_o), c - 1);
            if (c == rst_at) begin
                #1 rst_ni = 1'b0;
                #1 check_zero("async_rst");
                sel_exp = 0;
                go_i    = 1'b0;
                abort_i = 1'b0;
                @(negedge clk_i);
                check_zero("rst_hold");
                rst_ni = 1'b1;
                $display("draw id=%0d reset in cycle %0d plots=%0d", id, c, plots);
                return;
            end
            go_i        = (c == extra_go_at) || (go_in_done && c == done_c);
            abort_i     = (c == abort_at);
            screen_id_i = (c == extra_go_at) ? SEL_W'(1) : SEL_W'($urandom_range(0, 7));
        end
        go_i    = 1'b0;
        abort_i = 1'b0;
        $display("draw id=%0d abort_at=%0d extra_go=%0d go_in_done=%0d done_cycle=%0d plots=%0d",
                 id, abort_at, extra_go_at, go_in_done, done_c, plots);
    endtask

    initial begin
        int id;
        int ab;
        int eg;
        #2 check_zero("in_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_zero("after_release");

        run_draw(2, 0, 5, 1'b0, 0);
        run_draw(2, 6, 0, 1'b0, 0);
        run_draw(5, 0, 0, 1'b0, 0);

        // go together with abort while idle must be dropped
        @(negedge clk_i);
        go_i = 1'b1;
        abort_i = 1'b1;
        screen_id_i = SEL_W'(3);
        @(negedge clk_i);
        go_i = 1'b0;
        abort_i = 1'b0;
        check_val("go_abort.busy", 32'(busy_o), 0);
        check_val("go_abort.done", 32'(done_o), 0);
        @(negedge clk_i);
        check_val("go_abort.busy2", 32'(busy_o), 0);
        check_val("go_abort.sel", 32'(rom_sel_o), sel_exp);
        $display("go+abort in idle ignored check done");

        run_draw(2, 0, 0, 1'b0, 4);
        run_draw(0, 0, 0, 1'b1, 0);
        run_draw(3, N_PIX + ROM_LAT, 0, 1'b0, 0);

        for (int t = 0; t < 20; t++) begin
            id = $urandom_range(0, 5);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N_PIX + ROM_LAT + 1) : 0;
            eg = ($urandom_range(0, 1) == 0) ? $urandom_range(2, N_PIX) : 0;
            if (ab != 0 && eg >= ab) eg = 0;
            if (id >= NUM_SCREENS) begin
                ab = 0;
                eg = 0;
            end
            run_draw(id, ab, eg, 1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
